// File: rtl/fb_pkg.sv
// fb_pkg: shared definitions for the frame-buffer stream reader.
//   fb_state_e      - reader sequencing states
//   BUF_PORT_W      - width of the buffer index supplied by the switcher
//   fb_buffer_base  - byte base address of a given frame buffer
package fb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_ISSUE,
        ST_WAIT_CREDIT,
        ST_DRAIN,
        ST_VSYNC
    } fb_state_e;

    localparam int unsigned BUF_PORT_W = 2;

    function automatic logic [31:0] fb_buffer_base(
        input logic [31:0]           frame_base,
        input logic [31:0]           stride,
        input logic [BUF_PORT_W-1:0] port
    );
        return frame_base + stride * {{(32-BUF_PORT_W){1'b0}}, port};
    endfunction

endpackage

// File: rtl/fb_sync_fifo.sv
// fb_sync_fifo: show-ahead synchronous FIFO (head word visible on rd_data
// whenever empty is low; rd_en consumes it).
// Ports:
//   clk, reset_n    - clock, synchronous active-low reset (clears pointers)
//   wr_en, wr_data  - write port (ignored when full)
//   rd_en, rd_data  - read/pop port (ignored when empty)
//   used            - current occupancy, 0..DEPTH
//   empty, full     - occupancy flags
// DEPTH must be a power of two.
module fb_sync_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   used,
    output logic                     empty,
    output logic                     full
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_wr, do_rd;

    // Pointers carry one extra wrap bit, so the difference is the occupancy.
    assign used    = wr_ptr_q - rd_ptr_q;
    assign empty   = (used == '0);
    assign full    = used[AW];
    assign do_wr   = wr_en & ~full;
    assign do_rd   = rd_en & ~empty;
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/fb_stream_reader.sv
// fb_stream_reader: fetches one frame per start from the SDRAM buffer chosen
// by buffer_port using Avalon-MM bursts and emits it as an Avalon-ST pixel
// stream with sop/eop; pulses buffer_vsync when the frame has been delivered.
// Ports:
//   clk, reset_n           - clock, synchronous active-low reset
//   enable                 - start/continue frame fetching
//   buffer_port            - buffer index, sampled once per frame
//   buffer_vsync           - one-cycle frame-complete pulse
//   avm_*                  - Avalon-MM burst read master (registered requests)
//   st_*                   - Avalon-ST pixel source
//   underrun_count         - saturating starvation counter
// Optional feature macro: FB_READER_UNDERRUN_CNT_EN adds underrun_count.
module fb_stream_reader
    import fb_pkg::*;
#(
    parameter logic [31:0] FRAME_BASE    = 32'h0000_0000,
    parameter logic [31:0] BUFFER_STRIDE = 32'h0010_0000,
    parameter int unsigned H_RES         = 640,
    parameter int unsigned V_RES         = 480,
    parameter int unsigned PIXEL_W       = 16,
    parameter int unsigned BURST_LEN     = 8,
    parameter int unsigned FIFO_DEPTH    = 32
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         enable,
    input  logic [BUF_PORT_W-1:0]        buffer_port,
    output logic                         buffer_vsync,
    output logic [31:0]                  avm_address,
    output logic                         avm_read,
    output logic [$clog2(BURST_LEN):0]   avm_burstcount,
    input  logic                         avm_waitrequest,
    input  logic [PIXEL_W-1:0]           avm_readdata,
    input  logic                         avm_readdatavalid,
    output logic [PIXEL_W-1:0]           st_data,
    output logic                         st_valid,
    input  logic                         st_ready,
    output logic                         st_sop,
    output logic                         st_eop
`ifdef FB_READER_UNDERRUN_CNT_EN
    ,
    output logic [15:0]                  underrun_count
`endif
);

    localparam int unsigned TOTAL_PIX   = H_RES * V_RES;
    localparam int unsigned N_BURSTS    = TOTAL_PIX / BURST_LEN;
    localparam int unsigned BURST_BYTES = BURST_LEN * PIXEL_W / 8;
    localparam int unsigned CNT_W       = $clog2(TOTAL_PIX + 1);
    localparam int unsigned BC_W        = $clog2(N_BURSTS + 1);
    localparam int unsigned LVL_W       = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SUM_W       = LVL_W + 1;
    localparam int unsigned BCNT_W      = $clog2(BURST_LEN) + 1;

    fb_state_e          state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic               read_q, read_d;
    logic [BCNT_W-1:0]  bcount_q, bcount_d;
    logic [BC_W-1:0]    bursts_q, bursts_d;
    logic [CNT_W-1:0]   pix_q, pix_d;
    logic [LVL_W-1:0]   outst_q, outst_d;

    logic [LVL_W-1:0]   fifo_used;
    logic               fifo_empty;
    logic               fifo_full;
    logic [PIXEL_W-1:0] fifo_dout;
    logic               accept, pop, last_burst, credit_ok;
    logic [SUM_W-1:0]   level_next;
    logic               unused_fifo_full;

    fb_sync_fifo #(
        .WIDTH (PIXEL_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (avm_readdatavalid),
        .wr_data (avm_readdata),
        .rd_en   (pop),
        .rd_data (fifo_dout),
        .used    (fifo_used),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    // The credit check keeps the FIFO from ever filling past capacity, so
    // the full flag carries no information here.
    assign unused_fifo_full = fifo_full;

    assign accept     = read_q & ~avm_waitrequest;
    assign st_valid   = ~fifo_empty;
    assign pop        = st_valid & st_ready;
    assign last_burst = (bursts_q == BC_W'(N_BURSTS - 1));

    // Words committed to the FIFO after this edge (stored + in flight),
    // counting a burst accepted now and a pixel popped now. The next burst
    // may go out only if its words will also fit.
    assign level_next = SUM_W'(fifo_used) + SUM_W'(outst_q)
                      + (accept ? SUM_W'(BURST_LEN) : '0)
                      - (pop ? SUM_W'(1) : '0);
    assign credit_ok  = (level_next + SUM_W'(BURST_LEN)) <= SUM_W'(FIFO_DEPTH);

    always_comb begin
        outst_d = outst_q;
        if (accept)            outst_d = outst_d + LVL_W'(BURST_LEN);
        if (avm_readdatavalid) outst_d = outst_d - LVL_W'(1);
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        read_d   = 1'b0;
        bursts_d = bursts_q;
        pix_d    = pop ? pix_q + CNT_W'(1) : pix_q;
        unique case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_START;
            end
            ST_START: begin
                addr_d   = fb_buffer_base(FRAME_BASE, BUFFER_STRIDE, buffer_port);
                bursts_d = '0;
                pix_d    = '0;
                read_d   = 1'b1;
                state_d  = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (accept) begin
                    addr_d   = addr_q + 32'(BURST_BYTES);
                    bursts_d = bursts_q + BC_W'(1);
                    if (last_burst)     state_d = ST_DRAIN;
                    else if (credit_ok) read_d  = 1'b1;
                    else                state_d = ST_WAIT_CREDIT;
                end else begin
                    read_d = 1'b1;
                end
            end
            ST_WAIT_CREDIT: begin
                if (credit_ok) begin
                    read_d  = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (pop && pix_q == CNT_W'(TOTAL_PIX - 1)) state_d = ST_VSYNC;
            end
            ST_VSYNC: begin
                addr_d  = '0;
                state_d = enable ? ST_START : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        bcount_d = read_d ? BCNT_W'(BURST_LEN) : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            read_q   <= 1'b0;
            bcount_q <= '0;
            bursts_q <= '0;
            pix_q    <= '0;
            outst_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            read_q   <= read_d;
            bcount_q <= bcount_d;
            bursts_q <= bursts_d;
            pix_q    <= pix_d;
            outst_q  <= outst_d;
        end
    end

    assign avm_address    = addr_q;
    assign avm_read       = read_q;
    assign avm_burstcount = bcount_q;
    assign buffer_vsync   = (state_q == ST_VSYNC);
    assign st_data        = st_valid ? fifo_dout : '0;
    assign st_sop         = st_valid & (pix_q == '0);
    assign st_eop         = st_valid & (pix_q == CNT_W'(TOTAL_PIX - 1));

`ifdef FB_READER_UNDERRUN_CNT_EN
    logic [15:0] underrun_q, underrun_d;
    logic        starving;

    // Starvation only counts once the frame has produced its first pixel.
    assign starving = (state_q == ST_ISSUE || state_q == ST_WAIT_CREDIT ||
                       state_q == ST_DRAIN) && st_ready && fifo_empty &&
                      (pix_q != '0);

    always_comb begin
        underrun_d = underrun_q;
        if (starving && underrun_q != '1) underrun_d = underrun_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) underrun_q <= '0;
        else          underrun_q <= underrun_d;
    end

    assign underrun_count = underrun_q;
`endif

endmodule

// File: doc/fb_stream_reader.md
# fb_stream_reader

Avalon-MM burst reader that fetches one complete frame from the SDRAM frame buffer selected by a frame-buffer switcher and emits it as an Avalon-ST pixel stream with start/end-of-packet markers. It is the read-side counterpart of the camera MM writer: it consumes `buffer_port` and reports frame completion on `buffer_vsync`, so the switcher can rotate buffers. A small internal FIFO, with credit-based burst issue, decouples SDRAM latency from downstream backpressure.

## Interface
- `FRAME_BASE`, 32'h0000_0000, byte address of buffer 0
- `BUFFER_STRIDE`, 32'h0010_0000, byte distance between buffers
- `H_RES`, 640, pixels per line
- `V_RES`, 480, lines per frame
- `PIXEL_W`, 16, pixel/data width (multiple of 8)
- `BURST_LEN`, 8, words per burst; `H_RES*V_RES` must divide evenly by it
- `FIFO_DEPTH`, 32, FIFO entries (power of 2, ≥ 2*BURST_LEN)

Ports:
- `clk`  in  1  single clock
- `reset_n`  in  1  synchronous, active-low reset
- `enable`  in  1  start/continue frame fetching
- `buffer_port`  in  2  buffer index supplied by the switcher
- `buffer_vsync`  out  1  one-cycle pulse at frame completion
- `avm_address`  out  32  byte address
- `avm_read`  out  1  read request
- `avm_burstcount`  out  $clog2(BURST_LEN)+1  always BURST_LEN
- `avm_waitrequest`  in  1  slave stall
- `avm_readdata`  in  PIXEL_W  returned word
- `avm_readdatavalid`  in  1  returned word valid
- `st_data`  out  PIXEL_W  pixel
- `st_valid`  out  1  pixel valid
- `st_ready`  in  1  sink ready
- `st_sop`  out  1  first pixel of frame
- `st_eop`  out  1  last pixel of frame
- `underrun_count`  out  16  present only with `FB_READER_UNDERRUN_CNT_EN`

## Operation
- States: IDLE → START → ISSUE ⇄ WAIT_CREDIT → DRAIN → VSYNC → IDLE.
- IDLE: all outputs 0. On `enable`=1, go to START.
- START: latch `buffer_port`, compute base = FRAME_BASE + port*BUFFER_STRIDE, clear word and pixel counters, then go to ISSUE.
- ISSUE: hold `avm_read`=1 and `avm_address` stable until `avm_waitrequest`=0. On acceptance, advance the address by BURST_LEN*PIXEL_W/8 and add BURST_LEN to `outstanding`. After the last burst, go to DRAIN. Otherwise, go to WAIT_CREDIT if credit is insufficient.
- Credit rule: issue only when `fifo_used + outstanding + BURST_LEN ≤ FIFO_DEPTH`. The FIFO therefore never overflows, and `readdatavalid` is never stalled.
- Each `avm_readdatavalid` writes one word into the FIFO and decrements `outstanding`.
- Stream: `st_valid` = FIFO not empty. A pop happens on `st_valid & st_ready`. `st_sop`=1 when pixel count is 0; `st_eop`=1 when pixel count is `H_RES*V_RES-1`.
- DRAIN: wait for the eop handshake, then go to VSYNC.
- VSYNC: `buffer_vsync`=1 for exactly one cycle, then go to IDLE. If `enable` is still 1, the next frame starts immediately.
- `enable` deasserted mid-frame: the current frame completes, including vsync; then the block idles.
- `buffer_port` changes mid-frame are ignored. The value is sampled only in START.
- Reset mid-frame: all state, counters and the FIFO clear in one cycle. The bus slave shares `reset_n`, so no stale `readdatavalid` follows.

## Timing
- Reset values: all outputs 0 and `underrun_count`=0; state IDLE.
- The first `avm_read` asserts 2 cycles after IDLE samples `enable`=1.
- Read data latency: FIFO write on the `readdatavalid` cycle; `st_valid` asserts on the next cycle.
- Full throughput: 1 pixel/cycle when the slave sustains it.
- `buffer_vsync` is asserted the cycle after the eop handshake.
- `avm_*` outputs are registered and remain stable while `avm_waitrequest`=1.

## Configuration
- Macro: `FB_READER_UNDERRUN_CNT_EN`.
- With the macro defined:
  - `underrun_count` increments, saturating at 16'hFFFF, on each cycle with state ∈ {ISSUE, WAIT_CREDIT, DRAIN}, `st_ready`=1 and FIFO empty, excluding cycles before the first pixel of the frame.
  - The count clears only on reset.
- Without the macro: the port and counter are absent.

## Structure
- Package `fb_pkg`:
  - state enum
  - `BUF_PORT_W`=2
  - function computing buffer base address
- Sub-module `fb_sync_fifo`:
  - show-ahead, synchronous FIFO parameterised by width and depth
  - outputs `used`, `empty`, `full`

## Test plan
- Basic frame (H_RES=4, V_RES=2, BURST_LEN=4, FIFO_DEPTH=8, buffer_port=2, BUFFER_STRIDE='h100, zero-wait slave) → expect:
  - bursts at 'h200 and 'h208
  - 8 pixels out, sop on pixel 0, eop on pixel 7
  - one `buffer_vsync` pulse
- `st_ready` held 0 → expect:
  - FIFO fills to 8
  - no third burst issued
  - `outstanding+used` never exceeds 8
- `avm_waitrequest`=1 for 5 cycles → expect `avm_address`/`avm_read`/`avm_burstcount` unchanged for those cycles.
- `buffer_port` changes 2→1 mid-frame → expect the current frame to stay at 'h200. The next frame (enable held) starts at 'h100.
- `reset_n` low mid-frame → expect next cycle: IDLE, all outputs 0, FIFO empty. Restart yields a clean sop.
- With the macro, slave latency 10 and `st_ready`=1 → expect `underrun_count` to grow between bursts and to stay 0 with a zero-latency slave.
